// File: rtl/tap_tempo_meter_pkg.sv
// Shared types and constants for the tap tempo meter.
// Imported by the top level and the divider.
package tap_tempo_meter_pkg;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_TIMING = 2'd1,
        S_DIVIDE = 2'd2
    } state_t;

    localparam int LATENCY    = 33;
    localparam int DIV_BITS   = 28;
    localparam int DVS_BITS   = 26;
    localparam int CNT_BITS   = 24;
    localparam int HIST_DEPTH = 4;
    localparam int BPM_MAX    = 255;

    // Clamp a wide quotient into the 8-bit BPM range.
    function automatic logic [7:0] sat_bpm(input logic [DIV_BITS-1:0] q);
        return (q > DIV_BITS'(BPM_MAX)) ? 8'(BPM_MAX) : q[7:0];
    endfunction

endpackage

// File: rtl/tempo_divider.sv
// Sequential restoring divider, one quotient bit per cycle.
// Quotient is valid on the cycle o_done pulses.
module tempo_divider
    import tap_tempo_meter_pkg::*;
(
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic                i_start,
    input  logic [DIV_BITS-1:0] i_dividend,
    input  logic [DVS_BITS-1:0] i_divisor,
    output logic                o_busy,
    output logic                o_done,
    output logic [DIV_BITS-1:0] o_quotient
);

    logic [DVS_BITS-1:0] r_rem;
    logic [DVS_BITS-1:0] r_dvs;
    logic [DIV_BITS-1:0] r_q;
    logic [4:0]          r_cnt;
    logic [DVS_BITS:0]   w_trial;
    logic [DVS_BITS:0]   w_diff;

    // rem < divisor, so the trial fits in one extra bit and
    // the top bit of the difference is the borrow.
    assign w_trial    = {r_rem, r_q[DIV_BITS-1]};
    assign w_diff     = w_trial - {1'b0, r_dvs};
    assign o_quotient = r_q;

    // Load on start, then shift/subtract until the bit count runs out.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_rem  <= '0;
            r_dvs  <= '0;
            r_q    <= '0;
            r_cnt  <= '0;
            o_busy <= 1'b0;
            o_done <= 1'b0;
        end else begin
            o_done <= 1'b0;
            if (i_start) begin
                r_rem  <= '0;
                r_dvs  <= i_divisor;
                r_q    <= i_dividend;
                r_cnt  <= 5'(DIV_BITS);
                o_busy <= 1'b1;
            end else if (o_busy) begin
                if (r_cnt != 5'd0) begin
                    if (!w_diff[DVS_BITS]) begin
                        r_rem <= w_diff[DVS_BITS-1:0];
                        r_q   <= {r_q[DIV_BITS-2:0], 1'b1};
                    end else begin
                        r_rem <= w_trial[DVS_BITS-1:0];
                        r_q   <= {r_q[DIV_BITS-2:0], 1'b0};
                    end
                    r_cnt <= r_cnt - 5'd1;
                end else begin
                    o_busy <= 1'b0;
                    o_done <= 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/tap_tempo_meter.sv
// Tap tempo meter: times taps, averages the last four
// intervals and reports the tempo as an 8-bit BPM value.
module tap_tempo_meter
    import tap_tempo_meter_pkg::*;
#(
    parameter int CLK_HZ          = 1000000,
    parameter int DEBOUNCE_CYCLES = 20000,
    parameter int TIMEOUT_CYCLES  = 2000000,
    parameter int DEFAULT_BPM     = 120
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_tap,
    output logic [7:0] o_bpm,
    output logic       o_bpm_update,
    output logic       o_active,
    output logic       o_beat
);

    localparam int CLKS_PER_MIN = 60 * CLK_HZ;
    localparam logic [CNT_BITS-1:0] DEB = CNT_BITS'(DEBOUNCE_CYCLES);
    localparam logic [CNT_BITS-1:0] TMO = CNT_BITS'(TIMEOUT_CYCLES);

    logic r_sync0;
    logic r_sync1;
    logic r_prev;
    logic r_tap_pulse;

    state_t              r_state;
    logic [CNT_BITS-1:0] r_cnt;
    logic [2:0]          r_n;
    // The newest interval plus these three make the four-deep window.
    logic [CNT_BITS-1:0] r_hist [HIST_DEPTH-1];

    logic                w_timeout;
    logic                w_long;
    logic [2:0]          w_n_next;
    logic [DIV_BITS-1:0] w_dividend;
    logic [DVS_BITS-1:0] w_divisor;
    logic                w_start;
    logic                w_div_busy;
    logic                w_div_done;
    logic [DIV_BITS-1:0] w_quot;

    assign w_timeout  = (r_cnt >= TMO);
    assign w_long     = (r_cnt >= DEB);
    assign w_n_next   = (r_n == 3'(HIST_DEPTH)) ? r_n : r_n + 3'd1;
    assign w_dividend = DIV_BITS'(CLKS_PER_MIN * int'(w_n_next));
    assign w_divisor  = DVS_BITS'(r_cnt)
                      + DVS_BITS'(r_hist[0])
                      + DVS_BITS'(r_hist[1])
                      + DVS_BITS'(r_hist[2]);
    assign w_start    = (r_state == S_TIMING) && !w_timeout
                      && r_tap_pulse && w_long && !w_div_busy;

    // Synchronise the raw tap and turn its rising edge into a pulse.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sync0     <= 1'b0;
            r_sync1     <= 1'b0;
            r_prev      <= 1'b0;
            r_tap_pulse <= 1'b0;
        end else begin
            r_sync0     <= i_tap;
            r_sync1     <= r_sync0;
            r_prev      <= r_sync1;
            r_tap_pulse <= r_sync1 & ~r_prev;
        end
    end

    tempo_divider u_div (
        .i_clk      (i_clk),
        .i_rst_n    (i_rst_n),
        .i_start    (w_start),
        .i_dividend (w_dividend),
        .i_divisor  (w_divisor),
        .o_busy     (w_div_busy),
        .o_done     (w_div_done),
        .o_quotient (w_quot)
    );

    // Tempo FSM: counter, history, and all registered outputs.
    // The counter is set to 1 on a tap so that its value on the
    // next tap equals the number of cycles between the two taps.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state      <= S_IDLE;
            r_cnt        <= '0;
            r_n          <= '0;
            r_hist       <= '{default: '0};
            o_bpm        <= 8'(DEFAULT_BPM);
            o_bpm_update <= 1'b0;
            o_active     <= 1'b0;
            o_beat       <= 1'b0;
        end else begin
            o_beat       <= 1'b0;
            o_bpm_update <= 1'b0;
            r_cnt        <= w_timeout ? TMO : r_cnt + CNT_BITS'(1);
            case (r_state)
                S_IDLE: begin
                    if (r_tap_pulse) begin
                        o_beat  <= 1'b1;
                        r_cnt   <= CNT_BITS'(1);
                        r_state <= S_TIMING;
                    end
                end
                S_TIMING: begin
                    if (w_timeout) begin
                        r_hist   <= '{default: '0};
                        r_n      <= '0;
                        o_active <= 1'b0;
                        r_state  <= S_IDLE;
                        if (r_tap_pulse) begin
                            o_beat  <= 1'b1;
                            r_cnt   <= CNT_BITS'(1);
                            r_state <= S_TIMING;
                        end
                    end else if (w_start) begin
                        o_beat    <= 1'b1;
                        r_cnt     <= CNT_BITS'(1);
                        r_hist[0] <= r_cnt;
                        r_hist[1] <= r_hist[0];
                        r_hist[2] <= r_hist[1];
                        r_n       <= w_n_next;
                        r_state   <= S_DIVIDE;
                    end
                end
                S_DIVIDE: begin
                    if (r_tap_pulse && w_long) begin
                        o_beat <= 1'b1;
                        r_cnt  <= CNT_BITS'(1);
                    end
                    if (w_div_done) begin
                        o_bpm        <= sat_bpm(w_quot);
                        o_bpm_update <= 1'b1;
                        o_active     <= 1'b1;
                        r_state      <= S_TIMING;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_tap_tempo_meter.sv
// Directed bench for tap_tempo_meter with time-scaled parameters
// (CLK_HZ=1000, so BPM = 60000 * n / sum_of_intervals).
module tb_tap_tempo_meter;
    import tap_tempo_meter_pkg::*;

    logic       clk;
    logic       rst_n;
    logic       tap;
    logic [7:0] bpm;
    logic       bpm_update;
    logic       active;
    logic       beat;

    int checks = 0;
    int errors = 0;
    int beat_cnt = 0;
    int upd_cnt = 0;

    tap_tempo_meter #(
        .CLK_HZ          (1000),
        .DEBOUNCE_CYCLES (40),
        .TIMEOUT_CYCLES  (2000),
        .DEFAULT_BPM     (120)
    ) dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_tap        (tap),
        .o_bpm        (bpm),
        .o_bpm_update (bpm_update),
        .o_active     (active),
        .o_beat       (beat)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (beat) beat_cnt++;
        if (bpm_update) upd_cnt++;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic do_reset();
        rst_n = 1'b0;
        tap = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    // Raise tap now, hold 4 cycles, next tap starts gap cycles later.
    task automatic pulse_wait(input int gap);
        tap = 1'b1;
        repeat (4) @(negedge clk);
        tap = 1'b0;
        repeat (gap - 4) @(negedge clk);
    endtask

    task automatic test_reset();
        int u0;
        rst_n = 1'b0;
        tap = 1'b0;
        @(negedge clk);
        checks++;
        if (bpm !== 8'd120 || active !== 1'b0 || bpm_update !== 1'b0
            || beat !== 1'b0) begin
            errors++;
            $display("FAIL reset_state bpm=%0d act=%b upd=%b beat=%b want 120/0/0/0",
                     bpm, active, bpm_update, beat);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        u0 = upd_cnt;
        repeat (3000) @(negedge clk);
        checks++;
        if (upd_cnt !== u0) begin
            errors++;
            $display("FAIL reset_idle_updates got %0d want %0d", upd_cnt, u0);
        end
        checks++;
        if (bpm !== 8'd120 || active !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle_out bpm=%0d act=%b want 120/0", bpm, active);
        end
    endtask

    task automatic test_steady();
        int b0;
        int u0;
        do_reset();
        b0 = beat_cnt;
        u0 = upd_cnt;
        pulse_wait(500);
        tap = 1'b1;
        for (int i = 1; i <= 34; i++) begin
            @(negedge clk);
            if (i == 4) begin
                tap = 1'b0;
                checks++;
                if (beat !== 1'b1) begin
                    errors++;
                    $display("FAIL steady_beat got %b want 1", beat);
                end
            end
            if (i == LATENCY) begin
                checks++;
                if (bpm_update !== 1'b0) begin
                    errors++;
                    $display("FAIL steady_early_update got %b want 0", bpm_update);
                end
            end
            if (i == LATENCY + 1) begin
                checks++;
                if (bpm_update !== 1'b1 || bpm !== 8'd120) begin
                    errors++;
                    $display("FAIL steady_latency upd=%b bpm=%0d want 1/120",
                             bpm_update, bpm);
                end
            end
        end
        repeat (466) @(negedge clk);
        pulse_wait(500);
        checks++;
        if (bpm !== 8'd120 || active !== 1'b1) begin
            errors++;
            $display("FAIL steady_final bpm=%0d act=%b want 120/1", bpm, active);
        end
        checks++;
        if (beat_cnt - b0 !== 3 || upd_cnt - u0 !== 2) begin
            errors++;
            $display("FAIL steady_counts beats=%0d upds=%0d want 3/2",
                     beat_cnt - b0, upd_cnt - u0);
        end
    endtask

    task automatic test_averaging();
        int u0;
        do_reset();
        u0 = upd_cnt;
        pulse_wait(1000);
        for (int k = 0; k < 4; k++) begin
            pulse_wait((k == 3) ? 500 : 1000);
            checks++;
            if (bpm !== 8'd60) begin
                errors++;
                $display("FAIL avg_n%0d bpm got %0d want 60", k + 1, bpm);
            end
        end
        pulse_wait(100);
        checks++;
        if (bpm !== 8'd68) begin
            errors++;
            $display("FAIL avg_window bpm got %0d want 68", bpm);
        end
        checks++;
        if (upd_cnt - u0 !== 5) begin
            errors++;
            $display("FAIL avg_updates got %0d want 5", upd_cnt - u0);
        end
    endtask

    task automatic test_bounce();
        int b0;
        int u0;
        do_reset();
        b0 = beat_cnt;
        u0 = upd_cnt;
        pulse_wait(5);
        pulse_wait(595);
        checks++;
        if (beat_cnt - b0 !== 1) begin
            errors++;
            $display("FAIL bounce_beat got %0d want 1", beat_cnt - b0);
        end
        pulse_wait(40);
        checks++;
        if (bpm !== 8'd100) begin
            errors++;
            $display("FAIL bounce_bpm got %0d want 100", bpm);
        end
        pulse_wait(39);
        pulse_wait(100);
        checks++;
        if (bpm !== 8'd187) begin
            errors++;
            $display("FAIL debounce_edge_bpm got %0d want 187", bpm);
        end
        checks++;
        if (beat_cnt - b0 !== 3 || upd_cnt - u0 !== 2) begin
            errors++;
            $display("FAIL debounce_edge_counts beats=%0d upds=%0d want 3/2",
                     beat_cnt - b0, upd_cnt - u0);
        end
    endtask

    task automatic test_saturation();
        int b0;
        int u0;
        do_reset();
        pulse_wait(200);
        pulse_wait(200);
        checks++;
        if (bpm !== 8'd255 || active !== 1'b1) begin
            errors++;
            $display("FAIL sat_bpm bpm=%0d act=%b want 255/1", bpm, active);
        end
        pulse_wait(2200);
        checks++;
        if (active !== 1'b0 || bpm !== 8'd255) begin
            errors++;
            $display("FAIL timeout act=%b bpm=%0d want 0/255", active, bpm);
        end
        b0 = beat_cnt;
        u0 = upd_cnt;
        pulse_wait(1000);
        checks++;
        if (beat_cnt - b0 !== 1 || upd_cnt !== u0 || active !== 1'b0) begin
            errors++;
            $display("FAIL timeout_first_tap beats=%0d upds=%0d act=%b want 1/0/0",
                     beat_cnt - b0, upd_cnt - u0, active);
        end
        pulse_wait(100);
        checks++;
        if (bpm !== 8'd60 || active !== 1'b1 || upd_cnt - u0 !== 1) begin
            errors++;
            $display("FAIL timeout_restart bpm=%0d act=%b upds=%0d want 60/1/1",
                     bpm, active, upd_cnt - u0);
        end
    endtask

    task automatic test_reset_mid_divide();
        int u0;
        do_reset();
        pulse_wait(1000);
        pulse_wait(100);
        checks++;
        if (bpm !== 8'd60) begin
            errors++;
            $display("FAIL middiv_setup bpm got %0d want 60", bpm);
        end
        repeat (900) @(negedge clk);
        tap = 1'b1;
        repeat (4) @(negedge clk);
        tap = 1'b0;
        repeat (9) @(negedge clk);
        u0 = upd_cnt;
        rst_n = 1'b0;
        #1;
        checks++;
        if (bpm !== 8'd120 || active !== 1'b0 || bpm_update !== 1'b0) begin
            errors++;
            $display("FAIL middiv_async bpm=%0d act=%b upd=%b want 120/0/0",
                     bpm, active, bpm_update);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (50) @(negedge clk);
        checks++;
        if (upd_cnt !== u0) begin
            errors++;
            $display("FAIL middiv_no_update got %0d want %0d", upd_cnt, u0);
        end
        pulse_wait(750);
        pulse_wait(100);
        checks++;
        if (bpm !== 8'd80 || upd_cnt - u0 !== 1) begin
            errors++;
            $display("FAIL middiv_recover bpm=%0d upds=%0d want 80/1",
                     bpm, upd_cnt - u0);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        tap = 1'b0;
        @(negedge clk);
        test_reset();
        test_steady();
        test_averaging();
        test_bounce();
        test_saturation();
        test_reset_mid_divide();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/tap_tempo_meter.md
Name: tap_tempo_meter

Overview:
Inverse of the beat-clock generator: it measures tempo instead of producing it. The block times the interval between user taps on a button or pad and averages the last four intervals. It converts the average into an 8-bit BPM value that can drive the beat-clock generator's BPM input. It sits between the front-panel tap input and the audio controller's tempo register.

Parameters:
CLK_HZ, 1000000, CLK frequency in Hz; CLKS_PER_MIN = 60*CLK_HZ.
DEBOUNCE_CYCLES, 20000, minimum accepted interval; shorter taps are ignored as bounce.
TIMEOUT_CYCLES, 2000000, interval at which the measurement is abandoned (30 BPM at 1 MHz).
DEFAULT_BPM, 120, BPM value after reset.

Ports:
CLK  input  1  system clock
RST_N  input  1  asynchronous active-low reset
TAP  input  1  raw asynchronous tap input, active high
BPM  output  8  measured tempo; held between updates
BPM_UPDATE  output  1  one-cycle pulse when BPM is written
ACTIVE  output  1  high while at least one interval is in history and no timeout has occurred
BEAT  output  1  one-cycle pulse on every accepted tap

Behaviour:
- Reset (async, RST_N=0) sets: BPM=DEFAULT_BPM, BPM_UPDATE=0, ACTIVE=0, BEAT=0, history cleared (n=0), state IDLE, divider aborted.
- Input path: 2-flop synchronizer, then rising-edge detect, giving tap_pulse 3 cycles after the first CLK edge that samples TAP=1.
- Interval counter: 24-bit, cleared on each accepted tap, increments every cycle, saturates at TIMEOUT_CYCLES. The interval is the number of cycles between successive accepted tap_pulses.
- Tap acceptance rule: a tap_pulse with interval < DEBOUNCE_CYCLES is ignored. It produces no BEAT and the counter is not cleared. Interval == DEBOUNCE_CYCLES is accepted.
- States:
  - IDLE: no reference tap. An accepted tap asserts BEAT, clears the counter and moves to TIMING.
  - TIMING: an accepted tap asserts BEAT and shifts the interval into the 4-deep history, with n=min(n+1,4). It then forms dividend=CLKS_PER_MIN*n (28 bits) and divisor=sum of history (26 bits), starts the divider and moves to DIVIDE. If the counter reaches TIMEOUT_CYCLES, history is cleared, n=0, ACTIVE=0, BPM is held, and the state returns to IDLE. A tap arriving on the timeout cycle is treated as an IDLE first tap, so timeout wins.
  - DIVIDE: the divider runs one bit per cycle for 28 cycles. The counter keeps running. On done, BPM=min(quotient,255) with truncation, BPM_UPDATE pulses, ACTIVE=1, and the state returns to TIMING. A tap during DIVIDE cannot occur because DEBOUNCE_CYCLES exceeds the divide time. Should one occur anyway, it is ignored apart from BEAT and the counter clear.
- Latency: BPM and BPM_UPDATE change 33 cycles after the first CLK edge sampling TAP=1 (3 sync/edge + 1 load + 28 iterate + 1 output).
- Arithmetic: the divisor is never 0 because each interval is ≥ DEBOUNCE_CYCLES. The quotient is ≥ 30 with default parameters. Saturation to 255 applies to fast taps.
- Reset asserted mid-DIVIDE: no BPM_UPDATE is produced and BPM returns to DEFAULT_BPM.

Decomposition:
- Shared include tempo_defs.vh holds:
  - state encodings IDLE/TIMING/DIVIDE;
  - the constants LATENCY=33, DIV_BITS=28, HIST_DEPTH=4, BPM_MAX=255.
- One sub-module, tempo_divider: sequential restoring divider with 28-bit dividend, 26-bit divisor, ports start/busy/done/quotient, and async active-low reset.

Test Plan:
- Reset: RST_N low then high, no TAP -> BPM=120, ACTIVE=0, BPM_UPDATE never pulses over 3,000,000 cycles.
- Steady taps: TAP pulses every 500,000 cycles -> BEAT on each tap; after the 2nd tap BPM=120, with BPM_UPDATE exactly 33 cycles after the TAP edge; ACTIVE=1.
- Averaging: four intervals of 1,000,000, then one of 500,000 -> BPM 60 after each of the first four intervals; after the fifth, 240e6/3.5e6 -> BPM=68.
- Bounce: taps at cycles 0, 5,000 and 600,000 -> the 5,000 tap gives no BEAT; BPM=100; a tap at interval exactly 20,000 is accepted.
- Saturation and timeout: intervals of 200,000 -> BPM=255. Then no tap for 2,000,000 cycles -> ACTIVE falls and BPM holds 255. The next tap gives BEAT with no update; the following tap 1,000,000 later gives BPM=60 with n=1.
- Async reset mid-divide: assert RST_N 10 cycles after tap detect -> outputs reset immediately, no BPM_UPDATE pulse; the next two taps measure normally.
